// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end
package fetch_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INST_W-1:0] NOP = '0;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: first-word-fall-through {pc, instr} queue with flush and occupancy count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  entry_t                 wdata_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  entry_t mem_q [DEPTH];
  always_ff @(posedge CLK) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge CLK) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: owns the fetch PC, fetches over req/ack into a prefetch queue,
// and flushes on core redirects (late acks for abandoned requests are discarded).
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   CLK,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [INST_W-1:0]      mem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INST_W-1:0]      inst_data,
  output logic [ADDR_W-1:0]      inst_pc,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] queue_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, disc_q, disc_d;
  logic push, pop, room;
  logic [CW-1:0] count_n;
  entry_t head;
  assign pop = inst_valid && inst_ready && !redirect;
  assign push = state_q == REQ && mem_ack && !redirect;
  assign count_n = redirect ? '0 : queue_count + CW'(push) - CW'(pop);
  assign room = count_n < CW'(DEPTH);
  always_ff @(posedge CLK) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = redirect ? ((state_q == IDLE || mem_ack) ? REQ : DISCARD)
            : state_q == IDLE ? (room ? REQ : IDLE)
            : !mem_ack ? state_q
            : (state_q == DISCARD || room) ? REQ : IDLE;
  end
  always_comb begin
    mem_req = state_q != IDLE;
    mem_addr = state_q == DISCARD ? disc_q : pc_q;
  end
  // disc_q remembers the abandoned address so the outstanding request stays stable
  always_comb begin
    pc_d = redirect ? (redirect_pc & 32'hFFFF_FFFC) : push ? pc_q + 32'd4 : pc_q;
    disc_d = (redirect && state_q == REQ && !mem_ack) ? pc_q : disc_q;
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      pc_q <= RESET_PC;
      disc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      disc_q <= disc_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ('{pc: pc_q, instr: mem_rdata}),
    .head_o  (head),
    .count_o (queue_count)
  );
  assign inst_valid = queue_count != '0;
  assign inst_data = inst_valid ? head.instr : NOP;
  assign inst_pc = inst_valid ? head.pc : '0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: table-driven cycle vectors plus hand sequences for redirect/reset corners
module tb_instr_fetch_queue;
  logic CLK = 0, rst = 1, mem_req, mem_ack = 0, inst_valid, inst_ready = 0, redirect = 0;
  logic [31:0] mem_addr, mem_rdata = 0, inst_data, inst_pc, redirect_pc = 0;
  logic [2:0] queue_count;
  int total = 0, bad = 0;

  typedef struct {
    logic rst, ack;
    logic [31:0] rdata;
    logic ready, redir;
    logic [31:0] rpc;
    logic req;
    logic [31:0] addr;
    logic valid;
    logic [31:0] data, pc;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs [19];

  always #5 CLK = ~CLK;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .queue_count(queue_count)
  );

  function automatic vec_t mk(input logic r, a, input logic [31:0] d, input logic rd, rdr,
                              input logic [31:0] rp, input logic q, input logic [31:0] ad,
                              input logic v, input logic [31:0] dt, p, input logic [2:0] c);
    mk = '{r, a, d, rd, rdr, rp, q, ad, v, dt, p, c};
  endfunction

  function automatic logic [31:0] dw(input logic [31:0] a);
    dw = 32'h1000_0000 | a;
  endfunction

  task automatic step(input logic r, a, input logic [31:0] d, input logic rd, rdr, input logic [31:0] rp);
    rst = r; mem_ack = a; mem_rdata = d; inst_ready = rd; redirect = rdr; redirect_pc = rp;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic q, input logic [31:0] a, input logic v,
                       input logic [31:0] d, p, input logic [2:0] c);
    logic [100:0] got, exp;
    got = {mem_req, mem_addr, inst_valid, inst_data, inst_pc, queue_count};
    exp = {q, a, v, d, p, c};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b data=%h pc=%h cnt=%0d; expected req=%0b addr=%h valid=%0b data=%h pc=%h cnt=%0d",
               nm, mem_req, mem_addr, inst_valid, inst_data, inst_pc, queue_count, q, a, v, d, p, c);
    end
  endtask

  initial begin
    // each row: outputs expected now, then the inputs applied for the next edge
    vecs[0]  = mk(0,1'b0,0,1,0,0,          0,32'h0, 0,0,0,0);
    vecs[1]  = mk(0,1'b1,dw(32'h0),1,0,0,  1,32'h0, 0,0,0,0);
    vecs[2]  = mk(0,1'b1,dw(32'h4),1,0,0,  1,32'h4, 1,dw(32'h0),32'h0,1);
    vecs[3]  = mk(0,1'b1,dw(32'h8),1,0,0,  1,32'h8, 1,dw(32'h4),32'h4,1);
    vecs[4]  = mk(0,1'b1,dw(32'hC),0,0,0,  1,32'hC, 1,dw(32'h8),32'h8,1);
    vecs[5]  = mk(0,1'b1,dw(32'h10),0,0,0, 1,32'h10,1,dw(32'h8),32'h8,2);
    vecs[6]  = mk(0,1'b1,dw(32'h14),0,0,0, 1,32'h14,1,dw(32'h8),32'h8,3);
    vecs[7]  = mk(0,1'b1,32'hDEAD_BEEF,0,0,0, 0,32'h18,1,dw(32'h8),32'h8,4);
    vecs[8]  = mk(0,1'b0,0,1,0,0,          0,32'h18,1,dw(32'h8),32'h8,4);
    vecs[9]  = mk(0,1'b1,dw(32'h18),0,0,0, 1,32'h18,1,dw(32'hC),32'hC,3);
    vecs[10] = mk(0,1'b0,0,1,0,0,          0,32'h1C,1,dw(32'hC),32'hC,4);
    vecs[11] = mk(0,1'b0,0,1,0,0,          1,32'h1C,1,dw(32'h10),32'h10,3);
    vecs[12] = mk(0,1'b0,0,1,0,0,          1,32'h1C,1,dw(32'h14),32'h14,2);
    vecs[13] = mk(0,1'b0,0,1,0,0,          1,32'h1C,1,dw(32'h18),32'h18,1);
    vecs[14] = mk(0,1'b1,dw(32'h1C),1,0,0, 1,32'h1C,0,0,0,0);
    vecs[15] = mk(0,1'b1,dw(32'h20),1,1,32'h203, 1,32'h20,1,dw(32'h1C),32'h1C,1);
    vecs[16] = mk(0,1'b0,0,1,0,0,          1,32'h200,0,0,0,0);
    vecs[17] = mk(0,1'b1,dw(32'h200),1,0,0,1,32'h200,0,0,0,0);
    vecs[18] = mk(0,1'b0,0,0,0,0,          1,32'h204,1,dw(32'h200),32'h200,1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 32'h40);
    for (int i = 0; i < 19; i++) begin
      check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].data, vecs[i].pc, vecs[i].cnt);
      step(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
    end
    // reset while the request to 0x204 is outstanding, then a late ack
    step(1, 0, 0, 0, 0, 0);
    check("rst_mid", 0, 32'h0, 0, 0, 0, 0);
    step(0, 1, 32'hDEAD, 0, 0, 0);
    check("late_ack", 1, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("late_ack_nopush", 1, 32'h0, 0, 0, 0, 0);
    // redirect coinciding with an ack: acked word dropped
    step(0, 1, 32'hDEAD, 1, 1, 32'h8);
    check("redir_ack", 1, 32'h8, 0, 0, 0, 0);
    // slow memory: redirect mid-request goes through DISCARD
    step(0, 0, 0, 1, 0, 0);
    check("hold8", 1, 32'h8, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h103);
    check("disc8a", 1, 32'h8, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("disc8b", 1, 32'h8, 0, 0, 0, 0);
    step(0, 1, 32'hDEAD, 1, 0, 0);
    check("tgt100", 1, 32'h100, 0, 0, 0, 0);
    step(0, 1, 32'hABC, 0, 0, 0);
    check("first100", 1, 32'h104, 1, 32'hABC, 32'h100, 1);
    // two redirects during DISCARD: the later target wins
    step(0, 0, 0, 0, 1, 32'h500);
    check("disc2a", 1, 32'h104, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h601);
    check("disc2b", 1, 32'h104, 0, 0, 0, 0);
    step(0, 1, 32'hBAD, 0, 0, 0);
    check("latest", 1, 32'h600, 0, 0, 0, 0);
    // PC wraps past the top of the address space
    step(0, 1, 32'hBAD, 0, 1, 32'hFFFF_FFFE);
    check("wrap_req", 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(0, 1, 32'h77, 0, 0, 0);
    check("wrap", 1, 32'h0, 1, 32'h77, 32'hFFFF_FFFC, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
